// File: rtl/bot_hub_pkg.sv
// Shared constants and width helpers for the bot update hub.
package bot_hub_pkg;

  localparam int BOT_INFO_W    = 32;
  localparam int DEFAULT_SYNC  = 2;
  localparam int DEFAULT_N_CH  = 2;
  localparam int DEFAULT_OVR_W = 4;

  // Channel index width; a single channel still needs one bit for irq_ch.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bot_update_hub_if.sv
// Producer-side bundle of the update hub: strobes, info words, acks and status.
interface bot_update_hub_if
  import bot_hub_pkg::*;
#(
  parameter int N_CH   = DEFAULT_N_CH,
  parameter int INFO_W = BOT_INFO_W,
  parameter int OVR_W  = DEFAULT_OVR_W
) ();

  localparam int CH_W = ch_w(N_CH);

  logic [N_CH-1:0]        upd_in;
  logic [N_CH*INFO_W-1:0] info_in;
  logic [N_CH-1:0]        int_ack;
  logic [N_CH-1:0]        ovr_clr;
  logic [N_CH*INFO_W-1:0] info_out;
  logic [N_CH-1:0]        pending;
  logic                   irq;
  logic [CH_W-1:0]        irq_ch;
  logic [N_CH*OVR_W-1:0]  overrun_cnt;

  modport master (
    output upd_in, info_in, int_ack, ovr_clr,
    input  info_out, pending, irq, irq_ch, overrun_cnt
  );

  modport slave (
    input  upd_in, info_in, int_ack, ovr_clr,
    output info_out, pending, irq, irq_ch, overrun_cnt
  );

endinterface

// File: rtl/bot_hub_channel.sv
// One hub channel: strobe synchroniser, rising-edge detect, snapshot,
// sticky pending flag and saturating overrun counter.
module bot_hub_channel #(
  parameter int INFO_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int OVR_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_upd,
  input  logic [INFO_W-1:0] i_info,
  input  logic              i_ack,
  input  logic              i_ovr_clr,
  output logic [INFO_W-1:0] o_info,
  output logic              o_pending,
  output logic [OVR_W-1:0]  o_ovr_cnt
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic [INFO_W-1:0]      r_info;
  logic                   r_pending;
  logic [OVR_W-1:0]       r_ovr_cnt;
  logic                   w_edge;
  logic                   w_ovr_inc;

  assign w_edge    = r_sync[SYNC_STAGES-1] & ~r_hist;
  // An ack landing on the edge cycle consumed the previous update, so no loss.
  assign w_ovr_inc = w_edge & r_pending & ~i_ack & (r_ovr_cnt != {OVR_W{1'b1}});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync    <= '0;
      r_hist    <= 1'b0;
      r_info    <= '0;
      r_pending <= 1'b0;
      r_ovr_cnt <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_upd};
      r_hist <= r_sync[SYNC_STAGES-1];
      if (w_edge) begin
        r_info    <= i_info;
        r_pending <= 1'b1;
      end else if (i_ack) begin
        r_pending <= 1'b0;
      end
      if (i_ovr_clr) begin
        r_ovr_cnt <= '0;
      end else if (w_ovr_inc) begin
        r_ovr_cnt <= r_ovr_cnt + 1'b1;
      end
    end
  end

  assign o_info    = r_info;
  assign o_pending = r_pending;
  assign o_ovr_cnt = r_ovr_cnt;

endmodule

// File: rtl/bot_update_hub.sv
// Multi-channel update/interrupt hub: N_CH independent channels merged into
// one interrupt request with a lowest-index-first channel select.
module bot_update_hub
  import bot_hub_pkg::*;
#(
  parameter int N_CH        = DEFAULT_N_CH,
  parameter int INFO_W      = BOT_INFO_W,
  parameter int SYNC_STAGES = DEFAULT_SYNC,
  parameter int OVR_W       = DEFAULT_OVR_W
) (
  input  logic            clk,
  input  logic            reset,
  bot_update_hub_if.slave bus
);

  localparam int CH_W = ch_w(N_CH);

  logic [INFO_W-1:0] w_info    [N_CH];
  logic [OVR_W-1:0]  w_ovr_cnt [N_CH];
  logic [N_CH-1:0]   w_pending;
  logic [CH_W-1:0]   w_irq_ch;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      bot_hub_channel #(
        .INFO_W      (INFO_W),
        .SYNC_STAGES (SYNC_STAGES),
        .OVR_W       (OVR_W)
      ) u_channel (
        .clk       (clk),
        .reset     (reset),
        .i_upd     (bus.upd_in[gi]),
        .i_info    (bus.info_in[gi*INFO_W +: INFO_W]),
        .i_ack     (bus.int_ack[gi]),
        .i_ovr_clr (bus.ovr_clr[gi]),
        .o_info    (w_info[gi]),
        .o_pending (w_pending[gi]),
        .o_ovr_cnt (w_ovr_cnt[gi])
      );
    end
  endgenerate

  always_comb begin
    bus.info_out    = '0;
    bus.overrun_cnt = '0;
    for (int i = 0; i < N_CH; i++) begin
      bus.info_out[i*INFO_W +: INFO_W]  = w_info[i];
      bus.overrun_cnt[i*OVR_W +: OVR_W] = w_ovr_cnt[i];
    end
  end

  // Scan from the top so the lowest pending index is the last one written.
  always_comb begin
    w_irq_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_pending[i]) w_irq_ch = CH_W'(i);
    end
  end

  assign bus.pending = w_pending;
  assign bus.irq     = |w_pending;
  assign bus.irq_ch  = w_irq_ch;

endmodule

// File: tb/tb_bot_update_hub.sv
// Self-checking bench for bot_update_hub: directed scenarios plus a randomized
// run, all compared against a cycle-level behavioural model of the hub.
module tb_bot_update_hub;
  import bot_hub_pkg::*;

  localparam int N_CH   = 2;
  localparam int INFO_W = 32;
  localparam int SYNC   = 2;
  localparam int OVR_W  = 4;
  localparam int CH_W   = ch_w(N_CH);
  localparam int CNT_MAX = (1 << OVR_W) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bot_update_hub_if #(.N_CH(N_CH), .INFO_W(INFO_W), .OVR_W(OVR_W)) bus ();

  bot_update_hub #(
    .N_CH(N_CH), .INFO_W(INFO_W), .SYNC_STAGES(SYNC), .OVR_W(OVR_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: m_seen[c][k] is upd_in[c] as sampled k+1 clock edges ago.
  logic              m_pend [N_CH];
  logic [INFO_W-1:0] m_info [N_CH];
  int                m_cnt  [N_CH];
  logic [7:0]        m_seen [N_CH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_pend[c] = 1'b0;
      m_info[c] = '0;
      m_cnt[c]  = 0;
      m_seen[c] = '0;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < N_CH; c++) begin
      logic rise;
      rise = m_seen[c][SYNC-1] && !m_seen[c][SYNC];
      if (rise) begin
        if (m_pend[c] && !bus.int_ack[c] && m_cnt[c] < CNT_MAX) m_cnt[c]++;
        m_pend[c] = 1'b1;
        m_info[c] = bus.info_in[c*INFO_W +: INFO_W];
      end else if (bus.int_ack[c]) begin
        m_pend[c] = 1'b0;
      end
      if (bus.ovr_clr[c]) m_cnt[c] = 0;
      m_seen[c] = {m_seen[c][6:0], bus.upd_in[c]};
    end
  endtask

  task automatic check_model(input string tag);
    logic any;
    int   low;
    any = 1'b0;
    low = 0;
    for (int c = N_CH - 1; c >= 0; c--) begin
      chk($sformatf("%s pending[%0d]", tag, c), 64'(bus.pending[c]), 64'(m_pend[c]));
      chk($sformatf("%s info[%0d]", tag, c), 64'(bus.info_out[c*INFO_W +: INFO_W]), 64'(m_info[c]));
      chk($sformatf("%s ovr[%0d]", tag, c), 64'(bus.overrun_cnt[c*OVR_W +: OVR_W]), 64'(m_cnt[c]));
      if (m_pend[c]) begin
        any = 1'b1;
        low = c;
      end
    end
    chk({tag, " irq"}, 64'(bus.irq), 64'(any));
    chk({tag, " irq_ch"}, 64'(bus.irq_ch), 64'(low));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    #1;
    check_model(tag);
  endtask

  // One-cycle strobe followed by enough low time for the next edge.
  task automatic strobe(input int ch, input logic [INFO_W-1:0] word);
    bus.info_in[ch*INFO_W +: INFO_W] = word;
    bus.upd_in[ch] = 1'b1;
    tick("strobe");
    bus.upd_in[ch] = 1'b0;
    repeat (4) tick("strobe");
  endtask

  task automatic ack(input int ch);
    bus.int_ack[ch] = 1'b1;
    tick("ack");
    bus.int_ack[ch] = 1'b0;
  endtask

  initial begin
    bus.upd_in  = '0;
    bus.info_in = '0;
    bus.int_ack = '0;
    bus.ovr_clr = '0;
    model_reset();

    // Reset and idle
    repeat (3) tick("reset");
    chk("reset pending", 64'(bus.pending), 64'd0);
    chk("reset irq", 64'(bus.irq), 64'd0);
    chk("reset info", 64'(bus.info_out), 64'd0);
    reset = 1'b0;
    repeat (5) tick("idle");
    chk("idle pending", 64'(bus.pending), 64'd0);
    $display("phase reset/idle checked");

    // Single update, level strobe held high
    bus.info_in[31:0] = 32'h1234_5678;
    bus.upd_in[0] = 1'b1;
    tick("single e0");
    chk("single e0 pending", 64'(bus.pending), 64'd0);
    tick("single e1");
    chk("single e1 pending", 64'(bus.pending), 64'd0);
    tick("single e2");
    chk("single e2 pending", 64'(bus.pending), 64'b01);
    chk("single e2 irq", 64'(bus.irq), 64'd1);
    chk("single e2 irq_ch", 64'(bus.irq_ch), 64'd0);
    chk("single e2 info0", 64'(bus.info_out[31:0]), 64'h1234_5678);
    repeat (6) tick("single hold");
    bus.upd_in[0] = 1'b0;
    repeat (4) tick("single low");
    ack(0);
    chk("single ack pending", 64'(bus.pending), 64'd0);
    chk("single ack irq", 64'(bus.irq), 64'd0);
    chk("single level cnt", 64'(bus.overrun_cnt), 64'd0);
    $display("phase single update checked");

    // Priority
    bus.info_in = {32'hBBBB_0001, 32'hAAAA_0001};
    bus.upd_in  = 2'b11;
    tick("prio");
    bus.upd_in  = 2'b00;
    repeat (4) tick("prio");
    chk("prio both irq_ch", 64'(bus.irq_ch), 64'd0);
    chk("prio both pending", 64'(bus.pending), 64'b11);
    ack(0);
    chk("prio ack0 irq_ch", 64'(bus.irq_ch), 64'd1);
    chk("prio ack0 irq", 64'(bus.irq), 64'd1);
    ack(1);
    chk("prio ack1 irq", 64'(bus.irq), 64'd0);
    $display("phase priority checked");

    // Ack coinciding with the edge cycle of a second strobe
    strobe(0, 32'hA5A5_0000);
    bus.info_in[31:0] = 32'h5A5A_1111;
    bus.upd_in[0] = 1'b1;
    tick("coin e0");
    bus.upd_in[0] = 1'b0;
    tick("coin e1");
    ack(0);
    chk("coin pending0", 64'(bus.pending[0]), 64'd1);
    chk("coin ovr0", 64'(bus.overrun_cnt[3:0]), 64'd0);
    chk("coin info0", 64'(bus.info_out[31:0]), 64'h5A5A_1111);
    ack(0);
    $display("phase ack/edge coincidence checked");

    // Overrun, saturation and clear on channel 1
    strobe(1, 32'h0000_0C01);
    strobe(1, 32'h0000_0C02);
    chk("ovr two cnt1", 64'(bus.overrun_cnt[7:4]), 64'd1);
    chk("ovr two info1", 64'(bus.info_out[63:32]), 64'h0000_0C02);
    for (int i = 3; i <= 20; i++) strobe(1, 32'(i));
    chk("ovr sat cnt1", 64'(bus.overrun_cnt[7:4]), 64'd15);
    chk("ovr sat info1", 64'(bus.info_out[63:32]), 64'd20);
    bus.ovr_clr[1] = 1'b1;
    tick("clr");
    bus.ovr_clr[1] = 1'b0;
    chk("ovr clr cnt1", 64'(bus.overrun_cnt[7:4]), 64'd0);
    for (int i = 0; i < 3; i++) strobe(1, 32'hD000 + 32'(i));
    chk("ovr three cnt1", 64'(bus.overrun_cnt[7:4]), 64'd3);
    $display("phase overrun checked");

    // Asynchronous reset mid-operation
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("async pending", 64'(bus.pending), 64'd0);
    chk("async irq", 64'(bus.irq), 64'd0);
    chk("async irq_ch", 64'(bus.irq_ch), 64'd0);
    chk("async info", 64'(bus.info_out), 64'd0);
    chk("async ovr", 64'(bus.overrun_cnt), 64'd0);
    bus.upd_in[1] = 1'b1;
    repeat (2) tick("in reset");
    reset = 1'b0;
    repeat (3) tick("release high");
    chk("release edge pending1", 64'(bus.pending[1]), 64'd1);
    bus.upd_in[1] = 1'b0;
    repeat (4) tick("release low");
    ack(1);
    $display("phase async reset checked");

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < N_CH; c++) begin
        bus.upd_in[c]  = ($urandom_range(0, 2) == 0);
        bus.int_ack[c] = ($urandom_range(0, 5) == 0);
        bus.ovr_clr[c] = ($urandom_range(0, 19) == 0);
        bus.info_in[c*INFO_W +: INFO_W] = $urandom;
      end
      tick("rand");
    end
    $display("phase random traffic checked");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
